id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage of the RISC-V pipeline. It sits between the IF/ID register and the execute stage, and drives the read ports of `register_file`. Each cycle it splits the fetched instruction into fields, generates the immediate, reads operands, and bypasses a same-cycle writeback into those operands. It detects load-use hazards and holds the registered ID/EX bundle under a valid/ready handshake with flush support.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (32): operand, PC and immediate width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_valid` in 1: IF/ID holds a valid instruction.
- `if_instr` in 32: instruction word.
- `if_pc` in DATA_WIDTH: PC of `if_instr`.
- `id_ready` out 1: ID consumes the IF/ID entry this cycle.
- `rf_rs1`, `rf_rs2` out 5: register_file read addresses, combinational from `if_instr[19:15]` and `if_instr[24:20]`.
- `rf_rd1`, `rf_rd2` in DATA_WIDTH: register_file read data.
- `wb_wr` in 1, `wb_rd` in 5, `wb_wd` in DATA_WIDTH: the writeback port, shared with register_file.
- `flush` in 1: branch or jump redirect from EX.
- `ex_ready` in 1: EX accepts the ID/EX bundle.
- `ex_valid` out 1: bundle valid.
- `ex_pc`, `ex_rs1_val`, `ex_rs2_val`, `ex_imm` out DATA_WIDTH.
- `ex_rs1`, `ex_rs2`, `ex_rd` out 5.
- `ex_opcode` out 7, `ex_funct3` out 3, `ex_funct7b5` out 1.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_branch`, `ex_jump`, `ex_illegal` out 1.

## Operation
- **Formats**
  - R = 0110011.
  - I = 0010011, 0000011 (load), 1100111 (jalr).
  - S = 0100011.
  - B = 1100011.
  - U = 0110111, 0010111.
  - J = 1101111.
- **Immediate:** sign-extended per format; R-type gives 0. B and J have bit 0 forced to 0.
- **Register use:**
  - rs1 is used by R, I, S, B.
  - rs2 is used by R, S, B.
  - Unused fields never cause a hazard.
- **Controls:**
  - `reg_write` = R/I/U/J and rd != 0.
  - `mem_read` = load; `mem_write` = S; `branch` = B; `jump` = J or jalr.
- **Illegal opcode:** all controls 0 and `ex_illegal`=1; the instruction still occupies a slot.
- **WB bypass** (register_file writes at the edge, so the same-cycle read returns the old value): if `wb_wr` && `wb_rd`!=0 && `wb_rd`==rs1, the operand is `wb_wd`, else `rf_rd1`. The same rule applies to rs2.
- **Load-use hazard** `haz` = `ex_valid` && `ex_mem_read` && `ex_rd`!=0 && `if_valid` && (`ex_rd` matches a used rs1 or rs2).
- **Ready:** `id_ready` = `flush` | (`ex_ready` & !`haz`).
- **Register update priority** (highest first):
  1. `rst`: all `ex_*` = 0.
  2. `flush`: `ex_valid` <= 0; the IF/ID entry is discarded.
  3. !`ex_ready`: hold all `ex_*`.
  4. `haz`: bubble, `ex_valid` <= 0 with controls 0; IF/ID is held.
  5. Otherwise: load the decoded bundle, with `ex_valid` <= `if_valid`. If `if_valid`=0, controls are 0.
- Operands are captured at acceptance. Later writebacks are resolved by EX forwarding, not here.

## Timing
- Reset: every `ex_*` output is 0. `id_ready` is 1 after reset, given `ex_ready`=1.
- Latency: one cycle from acceptance to `ex_*`.
- Ready path: `id_ready` and `rf_rs*` are combinational; no register is in that path.
- Throughput: one instruction per cycle with no hazard.
- Load-use stall: exactly one bubble cycle. On the next cycle `ex_mem_read`=0, so the dependent instruction proceeds.
- `flush` together with `haz` or !`ex_ready`: flush wins, bubble inserted, `id_ready`=1.
- `wb_rd`=0 never bypasses. x0 always reads 0.
- Reset asserted mid-stall: outputs clear asynchronously; after release the hazard is re-evaluated from scratch.

## Structure
- `defs.vh` gains:
  - opcode constants `OP_LUI`, `OP_AUIPC`, `OP_JAL`, `OP_JALR`, `OP_BRANCH`, `OP_LOAD`, `OP_STORE`, `OP_IMM`, `OP_REG`;
  - format encodings `FMT_R`, `FMT_I`, `FMT_S`, `FMT_B`, `FMT_U`, `FMT_J`.
- One sub-module, `imm_gen`: combinational, (instr) -> (imm, fmt).
- Hazard logic, bypass logic and the ID/EX register stay in `id_stage`.

## Test plan
- **Decode:** `add x1,x2,x3` (0x003100B3), `rf_rd1`=5, `rf_rd2`=10.
  - Next cycle: `ex_valid`=1, `ex_rs1_val`=5, `ex_rs2_val`=10, `ex_rd`=1, `ex_reg_write`=1, `ex_imm`=0.
- **Bypass:** same add with `wb_wr`=1, `wb_rd`=2, `wb_wd`=7 in the same cycle.
  - `ex_rs1_val`=7.
  - With `wb_rd`=0 instead, `ex_rs1_val`=5.
- **Load-use:** `lw x5,0(x2)` (0x00012283) then `add x6,x5,x3` (0x00328333).
  - One cycle with `id_ready`=0 and a bubble.
  - The add issues on the following cycle.
  - The add issues without stall if its rs1 is x0-based.
- **Branch immediate:** `beq x3,x4,8` (0x00418463).
  - `ex_imm`=8, `ex_branch`=1, `ex_reg_write`=0.
  - `imm[12]`=1 sign-extends to 0xFFFFF000.
- **Flush and backpressure:**
  - `flush` with `ex_ready`=0: `ex_valid`=0 next cycle, `id_ready`=1.
  - `ex_ready`=0 for 3 cycles: `ex_*` is stable and `id_ready`=0.
- **Reset:** assert `rst` mid-stream between edges; all `ex_*` are 0 immediately. Illegal opcode 0x0000007F gives `ex_illegal`=1 with controls 0.

Source files
------------

// File: rtl/id_stage_pkg.sv
// ============================================================================
//  Module : id_stage_pkg
//  Brief  : Opcode, format and control definitions shared by the decode stage.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package id_stage_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // FMT_X marks an opcode outside the supported set
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_X = 3'd6
  } fmt_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic illegal;
  } ctrl_t;

  function automatic fmt_e opcode_fmt(input logic [6:0] op);
    case (op)
      OP_REG:                   return FMT_R;
      OP_IMM, OP_LOAD, OP_JALR: return FMT_I;
      OP_STORE:                 return FMT_S;
      OP_BRANCH:                return FMT_B;
      OP_LUI, OP_AUIPC:         return FMT_U;
      OP_JAL:                   return FMT_J;
      default:                  return FMT_X;
    endcase
  endfunction

  function automatic logic uses_rs1(input fmt_e f);
    return (f == FMT_R) || (f == FMT_I) || (f == FMT_S) || (f == FMT_B);
  endfunction

  function automatic logic uses_rs2(input fmt_e f);
    return (f == FMT_R) || (f == FMT_S) || (f == FMT_B);
  endfunction

  function automatic ctrl_t decode_ctrl(input logic [6:0] op, input fmt_e f,
                                        input logic [4:0] rd);
    ctrl_t c;
    c           = '0;
    c.reg_write = ((f == FMT_R) || (f == FMT_I) || (f == FMT_U) || (f == FMT_J))
                  && (rd != 5'd0);
    c.mem_read  = (op == OP_LOAD);
    c.mem_write = (f == FMT_S);
    c.branch    = (f == FMT_B);
    c.jump      = (f == FMT_J) || (op == OP_JALR);
    c.illegal   = (f == FMT_X);
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_stage_if.sv
// ============================================================================
//  Module : id_stage_if
//  Brief  : ID/EX bundle with its valid/ready handshake.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface id_stage_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  ex_ready;
  logic                  ex_valid;
  logic [DATA_WIDTH-1:0] ex_pc;
  logic [DATA_WIDTH-1:0] ex_rs1_val;
  logic [DATA_WIDTH-1:0] ex_rs2_val;
  logic [DATA_WIDTH-1:0] ex_imm;
  logic [4:0]            ex_rs1;
  logic [4:0]            ex_rs2;
  logic [4:0]            ex_rd;
  logic [6:0]            ex_opcode;
  logic [2:0]            ex_funct3;
  logic                  ex_funct7b5;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic                  ex_branch;
  logic                  ex_jump;
  logic                  ex_illegal;

  modport master (
    input  ex_ready,
    output ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_opcode, ex_funct3, ex_funct7b5, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_branch, ex_jump, ex_illegal
  );

  modport slave (
    output ex_ready,
    input  ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_opcode, ex_funct3, ex_funct7b5, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_branch, ex_jump, ex_illegal
  );
endinterface

`default_nettype wire

// File: rtl/id_stage_imm_gen.sv
// ============================================================================
//  Module : imm_gen
//  Brief  : Combinational instruction format classifier and immediate builder.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imm_gen
  import id_stage_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [31:0]           instr,
  output logic [DATA_WIDTH-1:0] imm,
  output fmt_e                  fmt
);

  logic signed [31:0] w_imm32;

  always_comb begin
    fmt = opcode_fmt(instr[6:0]);
    case (fmt)
      FMT_I:   w_imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   w_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
      FMT_U:   w_imm32 = {instr[31:12], 12'b0};
      FMT_J:   w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
    imm = DATA_WIDTH'(w_imm32);
  end

endmodule

`default_nettype wire

// File: rtl/id_stage.sv
// ============================================================================
//  Module : id_stage
//  Brief  : RISC-V decode stage with WB bypass, load-use stall and ID/EX register.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_stage
  import id_stage_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [31:0]           if_instr,
  input  logic [DATA_WIDTH-1:0] if_pc,
  output logic                  id_ready,
  output logic [4:0]            rf_rs1,
  output logic [4:0]            rf_rs2,
  input  logic [DATA_WIDTH-1:0] rf_rd1,
  input  logic [DATA_WIDTH-1:0] rf_rd2,
  input  logic                  wb_wr,
  input  logic [4:0]            wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_wd,
  input  logic                  flush,
  id_stage_if.master            ex
);

  logic [DATA_WIDTH-1:0] w_imm;
  fmt_e                  w_fmt;
  ctrl_t                 w_ctrl;
  logic [4:0]            w_rd;
  logic [DATA_WIDTH-1:0] w_rs1_val;
  logic [DATA_WIDTH-1:0] w_rs2_val;
  logic                  w_haz;

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_rs1_val;
  logic [DATA_WIDTH-1:0] r_rs2_val;
  logic [DATA_WIDTH-1:0] r_imm;
  logic [4:0]            r_rs1;
  logic [4:0]            r_rs2;
  logic [4:0]            r_rd;
  logic [6:0]            r_opcode;
  logic [2:0]            r_funct3;
  logic                  r_funct7b5;
  ctrl_t                 r_ctrl;

  imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm_gen (
    .instr (if_instr),
    .imm   (w_imm),
    .fmt   (w_fmt)
  );

  assign rf_rs1 = if_instr[19:15];
  assign rf_rs2 = if_instr[24:20];
  assign w_rd   = if_instr[11:7];
  assign w_ctrl = decode_ctrl(if_instr[6:0], w_fmt, w_rd);

  // The register file writes at the edge, so a same-cycle write must be bypassed
  always_comb begin
    if (rf_rs1 == 5'd0)
      w_rs1_val = '0;
    else if (wb_wr && (wb_rd == rf_rs1))
      w_rs1_val = wb_wd;
    else
      w_rs1_val = rf_rd1;

    if (rf_rs2 == 5'd0)
      w_rs2_val = '0;
    else if (wb_wr && (wb_rd == rf_rs2))
      w_rs2_val = wb_wd;
    else
      w_rs2_val = rf_rd2;
  end

  assign w_haz = r_valid && r_ctrl.mem_read && (r_rd != 5'd0) && if_valid &&
                 ((uses_rs1(w_fmt) && (r_rd == rf_rs1)) ||
                  (uses_rs2(w_fmt) && (r_rd == rf_rs2)));

  assign id_ready = flush | (ex.ex_ready & ~w_haz);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_val  <= '0;
      r_rs2_val  <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_opcode   <= '0;
      r_funct3   <= '0;
      r_funct7b5 <= 1'b0;
      r_ctrl     <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (ex.ex_ready) begin
      if (w_haz) begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
      end else begin
        r_valid    <= if_valid;
        r_pc       <= if_pc;
        r_rs1_val  <= w_rs1_val;
        r_rs2_val  <= w_rs2_val;
        r_imm      <= w_imm;
        r_rs1      <= rf_rs1;
        r_rs2      <= rf_rs2;
        r_rd       <= w_rd;
        r_opcode   <= if_instr[6:0];
        r_funct3   <= if_instr[14:12];
        r_funct7b5 <= if_instr[30];
        r_ctrl     <= if_valid ? w_ctrl : '0;
      end
    end
  end

  assign ex.ex_valid     = r_valid;
  assign ex.ex_pc        = r_pc;
  assign ex.ex_rs1_val   = r_rs1_val;
  assign ex.ex_rs2_val   = r_rs2_val;
  assign ex.ex_imm       = r_imm;
  assign ex.ex_rs1       = r_rs1;
  assign ex.ex_rs2       = r_rs2;
  assign ex.ex_rd        = r_rd;
  assign ex.ex_opcode    = r_opcode;
  assign ex.ex_funct3    = r_funct3;
  assign ex.ex_funct7b5  = r_funct7b5;
  assign ex.ex_reg_write = r_ctrl.reg_write;
  assign ex.ex_mem_read  = r_ctrl.mem_read;
  assign ex.ex_mem_write = r_ctrl.mem_write;
  assign ex.ex_branch    = r_ctrl.branch;
  assign ex.ex_jump      = r_ctrl.jump;
  assign ex.ex_illegal   = r_ctrl.illegal;

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
// ============================================================================
//  Module : tb_id_stage
//  Brief  : Directed self-checking bench for the decode stage.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_stage;

  localparam logic [31:0] ADD_X1 = 32'h003100B3;  // add x1,x2,x3
  localparam logic [31:0] LW_X5  = 32'h00012283;  // lw  x5,0(x2)
  localparam logic [31:0] ADD_X6 = 32'h00328333;  // add x6,x5,x3
  localparam logic [31:0] ADD_X0 = 32'h00300333;  // add x6,x0,x3
  localparam logic [31:0] BEQ_8  = 32'h00418463;  // beq x3,x4,8
  localparam logic [31:0] BEQ_NG = 32'h80000063;  // beq x0,x0,-4096
  localparam logic [31:0] ILLEG  = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_wr;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wd;
  logic        flush;

  int vectors    = 0;
  int miscompares = 0;

  id_stage_if #(.DATA_WIDTH(32)) bus ();

  id_stage #(.DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_valid (if_valid),
    .if_instr (if_instr),
    .if_pc    (if_pc),
    .id_ready (id_ready),
    .rf_rs1   (rf_rs1),
    .rf_rs2   (rf_rs2),
    .rf_rd1   (rf_rd1),
    .rf_rd2   (rf_rd2),
    .wb_wr    (wb_wr),
    .wb_rd    (wb_rd),
    .wb_wd    (wb_wd),
    .flush    (flush),
    .ex       (bus.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    rf_rd1 = '0; rf_rd2 = '0; wb_wr = 1'b0; wb_rd = '0; wb_wd = '0;
    flush = 1'b0; bus.ex_ready = 1'b1;
    step(); step();
    vectors++; if (bus.ex_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %h exp 0", bus.ex_valid); end
    vectors++; if (bus.ex_reg_write !== 1'b0) begin miscompares++; $display("FAIL reset_regwr got %h exp 0", bus.ex_reg_write); end
    vectors++; if (bus.ex_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h exp 0", bus.ex_pc); end
    vectors++; if (id_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %h exp 1", id_ready); end
    @(negedge clk); rst = 1'b0;
    step();
  endtask

  task automatic test_decode();
    if_valid = 1'b1; if_instr = ADD_X1; if_pc = 32'h100; rf_rd1 = 32'd5; rf_rd2 = 32'd10;
    #1;
    vectors++; if (rf_rs1 !== 5'd2) begin miscompares++; $display("FAIL dec_rfrs1 got %0d exp 2", rf_rs1); end
    vectors++; if (rf_rs2 !== 5'd3) begin miscompares++; $display("FAIL dec_rfrs2 got %0d exp 3", rf_rs2); end
    step();
    vectors++; if (bus.ex_valid !== 1'b1) begin miscompares++; $display("FAIL dec_valid got %h exp 1", bus.ex_valid); end
    vectors++; if (bus.ex_rs1_val !== 32'd5) begin miscompares++; $display("FAIL dec_rs1val got %0d exp 5", bus.ex_rs1_val); end
    vectors++; if (bus.ex_rs2_val !== 32'd10) begin miscompares++; $display("FAIL dec_rs2val got %0d exp 10", bus.ex_rs2_val); end
    vectors++; if (bus.ex_rd !== 5'd1) begin miscompares++; $display("FAIL dec_rd got %0d exp 1", bus.ex_rd); end
    vectors++; if (bus.ex_reg_write !== 1'b1) begin miscompares++; $display("FAIL dec_regwr got %h exp 1", bus.ex_reg_write); end
    vectors++; if (bus.ex_imm !== 32'h0) begin miscompares++; $display("FAIL dec_imm got %h exp 0", bus.ex_imm); end
    vectors++; if (bus.ex_pc !== 32'h100) begin miscompares++; $display("FAIL dec_pc got %h exp 100", bus.ex_pc); end
  endtask

  task automatic test_bypass();
    if_instr = ADD_X1; wb_wr = 1'b1; wb_rd = 5'd2; wb_wd = 32'd7;
    step();
    vectors++; if (bus.ex_rs1_val !== 32'd7) begin miscompares++; $display("FAIL byp_rs1 got %0d exp 7", bus.ex_rs1_val); end
    vectors++; if (bus.ex_rs2_val !== 32'd10) begin miscompares++; $display("FAIL byp_rs2 got %0d exp 10", bus.ex_rs2_val); end
    wb_rd = 5'd0;
    step();
    vectors++; if (bus.ex_rs1_val !== 32'd5) begin miscompares++; $display("FAIL byp_x0 got %0d exp 5", bus.ex_rs1_val); end
    wb_rd = 5'd3; wb_wd = 32'd99;
    step();
    vectors++; if (bus.ex_rs2_val !== 32'd99) begin miscompares++; $display("FAIL byp_rs2b got %0d exp 99", bus.ex_rs2_val); end
    wb_wr = 1'b0;
  endtask

  task automatic test_load_use();
    if_instr = LW_X5; if_pc = 32'h104;
    step();
    vectors++; if (bus.ex_mem_read !== 1'b1) begin miscompares++; $display("FAIL lu_memrd got %h exp 1", bus.ex_mem_read); end
    if_instr = ADD_X6; if_pc = 32'h108;
    #1;
    vectors++; if (id_ready !== 1'b0) begin miscompares++; $display("FAIL lu_stall got %h exp 0", id_ready); end
    step();
    vectors++; if (bus.ex_valid !== 1'b0) begin miscompares++; $display("FAIL lu_bubble got %h exp 0", bus.ex_valid); end
    vectors++; if (bus.ex_mem_read !== 1'b0) begin miscompares++; $display("FAIL lu_bubmr got %h exp 0", bus.ex_mem_read); end
    vectors++; if (id_ready !== 1'b1) begin miscompares++; $display("FAIL lu_release got %h exp 1", id_ready); end
    step();
    vectors++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd6) begin miscompares++; $display("FAIL lu_issue got v=%h rd=%0d exp v=1 rd=6", bus.ex_valid, bus.ex_rd); end
    if_instr = LW_X5;
    step();
    if_instr = ADD_X0; rf_rd1 = 32'd0;
    #1;
    vectors++; if (id_ready !== 1'b1) begin miscompares++; $display("FAIL lu_x0ready got %h exp 1", id_ready); end
    step();
    vectors++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd6) begin miscompares++; $display("FAIL lu_x0issue got v=%h rd=%0d exp v=1 rd=6", bus.ex_valid, bus.ex_rd); end
    rf_rd1 = 32'd5;
  endtask

  task automatic test_branch();
    if_instr = BEQ_8;
    step();
    vectors++; if (bus.ex_imm !== 32'd8) begin miscompares++; $display("FAIL br_imm got %h exp 8", bus.ex_imm); end
    vectors++; if (bus.ex_branch !== 1'b1) begin miscompares++; $display("FAIL br_branch got %h exp 1", bus.ex_branch); end
    vectors++; if (bus.ex_reg_write !== 1'b0) begin miscompares++; $display("FAIL br_regwr got %h exp 0", bus.ex_reg_write); end
    if_instr = BEQ_NG;
    step();
    vectors++; if (bus.ex_imm !== 32'hFFFFF000) begin miscompares++; $display("FAIL br_neg got %h exp fffff000", bus.ex_imm); end
  endtask

  task automatic test_flush_backpressure();
    if_instr = ADD_X1; if_pc = 32'h200;
    step();
    bus.ex_ready = 1'b0; flush = 1'b1;
    #1;
    vectors++; if (id_ready !== 1'b1) begin miscompares++; $display("FAIL fl_ready got %h exp 1", id_ready); end
    step();
    vectors++; if (bus.ex_valid !== 1'b0) begin miscompares++; $display("FAIL fl_valid got %h exp 0", bus.ex_valid); end
    flush = 1'b0; bus.ex_ready = 1'b1;
    step();
    bus.ex_ready = 1'b0; if_instr = BEQ_8; if_pc = 32'h300;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (id_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready[%0d] got %h exp 0", i, id_ready); end
      step();
      vectors++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd1 || bus.ex_pc !== 32'h200 || bus.ex_branch !== 1'b0)
        begin miscompares++; $display("FAIL bp_hold[%0d] got v=%h rd=%0d pc=%h br=%h exp v=1 rd=1 pc=200 br=0", i, bus.ex_valid, bus.ex_rd, bus.ex_pc, bus.ex_branch); end
    end
    bus.ex_ready = 1'b1;
    step();
    vectors++; if (bus.ex_pc !== 32'h300) begin miscompares++; $display("FAIL bp_resume got %h exp 300", bus.ex_pc); end
  endtask

  task automatic test_reset_mid();
    if_instr = LW_X5;
    step();
    if_instr = ADD_X6;
    #2 rst = 1'b1;
    #1;
    vectors++; if (bus.ex_valid !== 1'b0 || bus.ex_mem_read !== 1'b0 || bus.ex_rd !== 5'd0)
      begin miscompares++; $display("FAIL rmid_clear got v=%h mr=%h rd=%0d exp 0", bus.ex_valid, bus.ex_mem_read, bus.ex_rd); end
    vectors++; if (id_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_ready got %h exp 1", id_ready); end
    @(negedge clk); rst = 1'b0;
    step();
    vectors++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd6) begin miscompares++; $display("FAIL rmid_after got v=%h rd=%0d exp v=1 rd=6", bus.ex_valid, bus.ex_rd); end
  endtask

  task automatic test_illegal();
    if_instr = ILLEG;
    step();
    vectors++; if (bus.ex_illegal !== 1'b1) begin miscompares++; $display("FAIL ill_flag got %h exp 1", bus.ex_illegal); end
    vectors++; if (bus.ex_valid !== 1'b1) begin miscompares++; $display("FAIL ill_valid got %h exp 1", bus.ex_valid); end
    vectors++; if ({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_branch, bus.ex_jump} !== 5'b0)
      begin miscompares++; $display("FAIL ill_ctrl got %b exp 00000", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_branch, bus.ex_jump}); end
    if_valid = 1'b0;
    step();
    vectors++; if (bus.ex_valid !== 1'b0 || bus.ex_illegal !== 1'b0) begin miscompares++; $display("FAIL idle got v=%h ill=%h exp 0", bus.ex_valid, bus.ex_illegal); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_bypass();
    test_load_use();
    test_branch();
    test_flush_backpressure();
    test_reset_mid();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
